sobel_window_ctrl: RTL and testbench

Sequencer that feeds the Sobel gradient wrapper. It accepts a raster-order 8-bit pixel stream and keeps two line buffers plus a 3x3 column shift window. Each time a complete 3x3 neighbourhood exists, it presents the nine bytes as window_buffer, pulses start_calculations, and holds both until downstream accepts. It also tracks frame position, applies backpressure to the pixel source, and flags end of frame.

---
 rtl/sobel_window_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: raster-order pixel sequencer for the Sobel gradient
// wrapper. Two line buffers plus a 3x3 column shift window build each
// neighbourhood. A window is presented once (row, col) >= (2, 2), and it is
// held until downstream accepts it.
//
// Handshakes: a pixel transfers on a cycle where pix_valid && pix_ready.
// A window transfers on a cycle where start_calculations && calc_ready.
// window_buffer is stable while start_calculations && !calc_ready.
//
// Optional build macro SOBEL_WINCNT_EN adds the win_count output, which
// holds the number of window handshakes in the current frame.
module sobel_window_ctrl #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIX_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame_start,
   input  logic [PIX_W-1:0]     pix_in,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   output logic [9*PIX_W-1:0]   window_buffer,
   output logic                 start_calculations,
   input  logic                 calc_ready,
   output logic                 frame_done
`ifdef SOBEL_WINCNT_EN
   ,
   output logic [31:0]          win_count
`endif
);

   localparam int COL_W = $clog2(IMG_WIDTH);
   localparam int ROW_W = $clog2(IMG_HEIGHT);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_LAST   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [PIX_W-1:0]   lb0 [IMG_WIDTH];
   logic [PIX_W-1:0]   lb1 [IMG_WIDTH];
   logic [9*PIX_W-1:0] win_shift;
   logic               accept;
   logic               handshake;
   logic               at_row_end;
   logic               at_last;
   logic               win_ok;
   logic               arm;

   assign accept     = pix_valid && pix_ready;
   assign handshake  = start_calculations && calc_ready;
   assign at_row_end = (col == COL_LAST);
   assign at_last    = at_row_end && (row == ROW_LAST);
   assign win_ok     = (row >= ROW_TWO) && (col >= COL_TWO);
   assign arm        = (state == S_IDLE) && frame_start;

   // Shift left one column; the new right column is the pre-write line
   // buffer contents at this column (top, middle) plus the incoming pixel.
   assign win_shift = {pix_in,   window_buffer[9*PIX_W-1:7*PIX_W],
                       lb0[col], window_buffer[6*PIX_W-1:4*PIX_W],
                       lb1[col], window_buffer[3*PIX_W-1:PIX_W]};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs. A pixel is taken in ACTIVE
   // unless a window is pending and not being accepted this cycle.
   always_comb begin
      state_nxt  = state;
      pix_ready  = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (frame_start) begin
               state_nxt = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            pix_ready = !(start_calculations && !calc_ready);
            if (pix_valid && pix_ready && at_last) begin
               state_nxt = S_LAST;
            end
         end
         S_LAST: begin
            if (start_calculations && calc_ready) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            frame_done = 1'b1;
            state_nxt  = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Line buffers: the row above moves down and the new pixel takes its
   // place. Contents are not reset because every window reads only
   // locations written earlier in the same frame.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[col] <= lb0[col];
         lb0[col] <= pix_in;
      end
   end

   // Frame position, window shift register, and window-valid flag. The
   // flag re-arms in the same cycle as a handshake when a new window
   // completes, so windows run back to back at one pixel per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         row                <= '0;
         col                <= '0;
         window_buffer      <= '0;
         start_calculations <= 1'b0;
      end else begin
         if (arm) begin
            row <= '0;
            col <= '0;
         end else if (accept) begin
            if (at_row_end) begin
               col <= '0;
               row <= at_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (accept) begin
            window_buffer <= win_shift;
         end
         if (accept && win_ok) begin
            start_calculations <= 1'b1;
         end else if (handshake) begin
            start_calculations <= 1'b0;
         end
      end
   end

`ifdef SOBEL_WINCNT_EN
   // Window handshakes in the current frame; the count holds after DONE.
   always_ff @(posedge clk) begin
      if (rst || arm) begin
         win_count <= '0;
      end else if (handshake) begin
         win_count <= win_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl on a 4x4 frame. Pixel i of a frame
// carries value base + i; the bench model builds every expected window from
// that formula. Built with SOBEL_WINCNT_EN, it also checks win_count.
module tb_sobel_window_ctrl;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int P    = 8;
   localparam int NPIX = W * H;

   logic           clk = 1'b0;
   logic           rst;
   logic           frame_start;
   logic [P-1:0]   pix_in;
   logic           pix_valid;
   logic           pix_ready;
   logic [9*P-1:0] window_buffer;
   logic           start_calculations;
   logic           calc_ready;
   logic           frame_done;
`ifdef SOBEL_WINCNT_EN
   logic [31:0]    win_count;
`endif

   sobel_window_ctrl #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .PIX_W      (P)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .frame_start        (frame_start),
      .pix_in             (pix_in),
      .pix_valid          (pix_valid),
      .pix_ready          (pix_ready),
      .window_buffer      (window_buffer),
      .start_calculations (start_calculations),
      .calc_ready         (calc_ready),
      .frame_done         (frame_done)
`ifdef SOBEL_WINCNT_EN
      ,
      .win_count          (win_count)
`endif
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;

   logic [9*P-1:0] exp_q[$];
   logic [9*P-1:0] got_q[$];
   logic [P-1:0]   acc_q[$];
   int             acc_cyc_q[$];

   logic           tb_clear = 1'b0;
   int             first_sc;
   int             last_hs;
   int             done_cnt;
   int             done_cyc;
   int             hs_acc;
   int             stall_cyc;
   int             stab_bad;
   logic           prev_stall;
   logic [9*P-1:0] prev_wb;

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (tb_clear) begin
         got_q.delete();
         acc_q.delete();
         acc_cyc_q.delete();
         first_sc   = -1;
         last_hs    = -1;
         done_cnt   = 0;
         done_cyc   = -1;
         hs_acc     = 0;
         stall_cyc  = 0;
         stab_bad   = 0;
         prev_stall = 1'b0;
         prev_wb    = '0;
      end else begin
         if (pix_valid && pix_ready) begin
            acc_q.push_back(pix_in);
            acc_cyc_q.push_back(cyc);
         end
         if (start_calculations && first_sc < 0) first_sc = cyc;
         if (start_calculations && calc_ready) begin
            got_q.push_back(window_buffer);
            last_hs = cyc;
            if (pix_valid && pix_ready) hs_acc++;
         end
         if (start_calculations && !calc_ready) begin
            stall_cyc++;
            if (pix_ready) stab_bad++;
            if (prev_stall && window_buffer !== prev_wb) stab_bad++;
         end
         prev_stall = start_calculations && !calc_ready;
         prev_wb    = window_buffer;
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // ---------------- comparison helpers ----------------
   task automatic chk_i(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [9*P-1:0] obs, input logic [9*P-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: window at (r,c) holds pixels (r-2..r, c-2..c), row-major.
   task automatic build_exp(input int base);
      logic [9*P-1:0] w;
      exp_q.delete();
      for (int r = 2; r < H; r++) begin
         for (int c = 2; c < W; c++) begin
            w = '0;
            for (int dr = 0; dr < 3; dr++) begin
               for (int dc = 0; dc < 3; dc++) begin
                  w[P*(dr*3+dc) +: P] = P'(base + (r - 2 + dr) * W + (c - 2 + dc));
               end
            end
            exp_q.push_back(w);
         end
      end
   endtask

   // ---------------- driver ----------------
   // mode 0: gap-free, calc_ready=1
   // mode 1: calc_ready held low for 5 cycles at the first window
   // mode 2: random pix_valid/calc_ready gaps plus a mid-frame frame_start
   // abort_idx >= 0: stop once that many pixels are in and a window is pending
   // Returns at a falling edge.
   task automatic run_frame(input int mode, input int base, input int abort_idx, output int ok);
      int   idx;
      int   stall_left;
      int   post;
      logic stall_used;
      logic seen_done;
      logic pv;
      logic cr;
      idx        = 0;
      stall_left = 0;
      post       = 0;
      stall_used = 1'b0;
      seen_done  = 1'b0;
      ok         = 0;
      build_exp(base);
      tb_clear    = 1'b1;
      frame_start = 1'b1;
      pix_valid   = 1'b0;
      calc_ready  = 1'b0;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      tb_clear    = 1'b0;
      for (int n = 0; n < 300; n++) begin
         pv = 1'b1;
         cr = 1'b1;
         if (mode == 1) begin
            if (start_calculations && !stall_used) begin
               stall_used = 1'b1;
               stall_left = 5;
            end
            if (stall_left > 0) begin
               cr = 1'b0;
               stall_left--;
            end
         end else if (mode == 2) begin
            pv = ($urandom_range(0, 3) != 0);
            cr = ($urandom_range(0, 2) != 0);
         end
         if (abort_idx >= 0 && idx >= abort_idx) begin
            pv = 1'b0;
            cr = 1'b0;
         end else if (idx >= NPIX) begin
            pv = 1'b1;
         end
         pix_valid   = pv;
         calc_ready  = cr;
         pix_in      = !pv ? P'($urandom) : (idx < NPIX) ? P'(base + idx) : 8'hEE;
         frame_start = (mode == 2 && n == 12);
         @(negedge clk);
         if (pix_valid && pix_ready) idx++;
         if (abort_idx >= 0 && idx >= abort_idx && start_calculations && !calc_ready) begin
            ok = 1;
            break;
         end
         if (seen_done) post++;
         if (frame_done) seen_done = 1'b1;
         if (post == 3) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      pix_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   // Checks common to every complete frame, plus per-mode extras.
   task automatic check_frame(input string tag, input int mode, input int base, input int ok);
      int bad;
      chk_i({tag, "_finished"}, ok, 1);
      chk_i({tag, "_win_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         chk_w($sformatf("%s_win%0d", tag, i), (i < got_q.size()) ? got_q[i] : '1, exp_q[i]);
      end
      chk_i({tag, "_pix_count"}, acc_q.size(), NPIX);
      bad = 0;
      for (int i = 0; i < acc_q.size(); i++) begin
         if (acc_q[i] !== P'(base + i)) bad++;
      end
      chk_i({tag, "_pix_order_bad"}, bad, 0);
      chk_i({tag, "_done_pulses"}, done_cnt, 1);
      chk_i({tag, "_done_after_last_hs"}, done_cyc, last_hs + 1);
      chk_i({tag, "_idle_pix_ready"}, int'(pix_ready), 0);
`ifdef SOBEL_WINCNT_EN
      chk_i({tag, "_win_count_port"}, int'(win_count), (W - 2) * (H - 2));
`endif
      if (mode == 0) begin
         chk_i({tag, "_first_sc_latency"}, first_sc, (acc_cyc_q.size() > 10) ? acc_cyc_q[10] + 1 : -2);
         chk_i({tag, "_hs_with_accept"}, hs_acc, 3);
      end
      if (mode == 1) begin
         chk_i({tag, "_stall_cycles"}, stall_cyc, 5);
         chk_i({tag, "_stall_unstable"}, stab_bad, 0);
         chk_i({tag, "_hs_with_accept"}, hs_acc, 3);
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int ok;
      rst         = 1'b1;
      frame_start = 1'b0;
      pix_valid   = 1'b0;
      pix_in      = '0;
      calc_ready  = 1'b0;
      first_sc    = -1;
      last_hs     = -1;
      done_cnt    = 0;
      done_cyc    = -1;
      hs_acc      = 0;
      stall_cyc   = 0;
      stab_bad    = 0;
      prev_stall  = 1'b0;
      prev_wb     = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_i("rst_pix_ready", int'(pix_ready), 0);
      chk_i("rst_start", int'(start_calculations), 0);
      chk_i("rst_frame_done", int'(frame_done), 0);
      chk_w("rst_window", window_buffer, '0);
`ifdef SOBEL_WINCNT_EN
      chk_i("rst_win_count", int'(win_count), 0);
`endif

      // pix_valid in IDLE is ignored.
      @(posedge clk);
      #1;
      pix_valid = 1'b1;
      pix_in    = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_i($sformatf("idle_pix_ready_%0d", i), int'(pix_ready), 0);
         @(posedge clk);
         #1;
      end
      pix_valid = 1'b0;
      chk_i("idle_no_accept", acc_q.size(), 0);
      chk_i("idle_no_window", int'(start_calculations), 0);

      // Frame A: gap-free.
      run_frame(0, 0, -1, ok);
      check_frame("gapfree", 0, 0, ok);

      // Frame B: first window stalled for 5 cycles.
      @(posedge clk);
      #1;
      run_frame(1, 0, -1, ok);
      check_frame("stall", 1, 0, ok);

      // Reset in row 3 with a window pending.
      @(posedge clk);
      #1;
      run_frame(0, 0, 15, ok);
      chk_i("abort_pending_reached", ok, 1);
      chk_i("abort_windows_before", got_q.size(), 2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_i("abort_pix_ready", int'(pix_ready), 0);
      chk_i("abort_start", int'(start_calculations), 0);
      chk_i("abort_frame_done", int'(frame_done), 0);
      chk_w("abort_window", window_buffer, '0);
`ifdef SOBEL_WINCNT_EN
      chk_i("abort_win_count", int'(win_count), 0);
`endif
      repeat (3) @(negedge clk);
      chk_i("abort_no_done", done_cnt, 0);

      // Frame C: fresh frame after the abort.
      @(posedge clk);
      #1;
      run_frame(0, 8'h40, -1, ok);
      check_frame("after_abort", 0, 8'h40, ok);

      // Frame D: random gaps and an ignored mid-frame frame_start.
      @(posedge clk);
      #1;
      run_frame(2, 8'h80, -1, ok);
      check_frame("random", 2, 8'h80, ok);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
